// File: rtl/result_reader.sv
// Streams NUM_RES result words out of data memory on a valid/ready port.
// Define RES_CHECKSUM_EN to append a running-sum beat after the results.
module result_reader #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int RES_BASE = 0,
  parameter int NUM_RES  = 43
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_adr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = $clog2(NUM_RES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RES - 1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(RES_BASE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_SEND,
`ifdef RES_CHECKSUM_EN
    S_CSUM,
`endif
    S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_W-1:0] mem_adr_q, mem_adr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              xfer;
  logic              is_last;
  logic [IDX_W-1:0]  idx_inc;

`ifdef RES_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
`endif

  assign xfer    = out_valid_q & out_ready;
  assign is_last = (idx_q == LAST_IDX);
  assign idx_inc = idx_q + IDX_W'(1);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mem_rd_en_d = 1'b0;
    mem_adr_d   = mem_adr_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
`ifdef RES_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_RD;
          mem_rd_en_d = 1'b1;
          mem_adr_d   = BASE + ADDR_W'(idx_q);
`ifdef RES_CHECKSUM_EN
          sum_d       = '0;
`endif
        end
      end
      S_RD: state_d = S_CAP;
      S_CAP: begin
        state_d     = S_SEND;
        out_data_d  = mem_rdata;
        out_valid_d = 1'b1;
`ifdef RES_CHECKSUM_EN
        out_last_d  = 1'b0;
`else
        out_last_d  = is_last;
`endif
      end
      S_SEND: begin
        if (!xfer) begin
          out_valid_d = 1'b1;
        end else if (is_last) begin
`ifdef RES_CHECKSUM_EN
          // Checksum beat includes the word just accepted.
          sum_d       = sum_q + out_data_q;
          state_d     = S_CSUM;
          out_valid_d = 1'b1;
          out_data_d  = sum_q + out_data_q;
          out_last_d  = 1'b1;
`else
          state_d     = S_FIN;
          done_d      = 1'b1;
          out_last_d  = 1'b0;
`endif
        end else begin
`ifdef RES_CHECKSUM_EN
          sum_d       = sum_q + out_data_q;
`endif
          idx_d       = idx_inc;
          state_d     = S_RD;
          mem_rd_en_d = 1'b1;
          mem_adr_d   = BASE + ADDR_W'(idx_inc);
          out_last_d  = 1'b0;
        end
      end
`ifdef RES_CHECKSUM_EN
      S_CSUM: begin
        if (xfer) begin
          state_d    = S_FIN;
          done_d     = 1'b1;
          out_last_d = 1'b0;
        end else begin
          out_valid_d = 1'b1;
        end
      end
`endif
      S_FIN: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      mem_rd_en_q <= 1'b0;
      mem_adr_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_adr_q   <= mem_adr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef RES_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sum_q <= '0;
    else     sum_q <= sum_d;
  end
`endif

  assign mem_rd_en = mem_rd_en_q;
  assign mem_adr   = mem_adr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
